// File: rtl/dm_responder.sv
`default_nettype none
// ============================================================================
// Module   : dm_responder
// Brief    : M-stage data memory with byte-lane writes, combinational reads,
//            range checking and a show-ahead trace FIFO of accepted writes.
// Revision : 1.0 - initial release
// ============================================================================
module dm_responder #(
    parameter int DEPTH       = 3072,
    parameter int TRACE_DEPTH = 8,
    parameter int CNT_W       = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [31:0]                  m_data_addr,
    input  logic [31:0]                  m_data_wdata,
    input  logic [3:0]                   m_data_byteen,
    input  logic [31:0]                  m_inst_addr,
    output logic [31:0]                  m_data_rdata,
    output logic                         trace_valid,
    input  logic                         trace_ready,
    output logic [31:0]                  trace_pc,
    output logic [31:0]                  trace_addr,
    output logic [31:0]                  trace_data,
    output logic [$clog2(TRACE_DEPTH):0] trace_count,
    output logic                         trace_ovf,
    output logic [CNT_W-1:0]             drop_cnt,
    output logic                         oob_err,
    output logic [CNT_W-1:0]             oob_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = $clog2(TRACE_DEPTH);

    logic [31:0]    mem_q [DEPTH];
    logic [31:0]    tpc_q [TRACE_DEPTH];
    logic [31:0]    tadr_q[TRACE_DEPTH];
    logic [31:0]    tdat_q[TRACE_DEPTH];

    logic [29:0]    idx;
    logic           in_range;
    logic [31:0]    cur_word;
    logic [31:0]    merged;
    logic           any_be;
    logic           wr_en;
    logic           oob_wr;
    logic           oob_rd;
    logic           full;
    logic           pop;
    logic           do_push;
    logic           drop;
    logic           addr_lsb_unused;

    logic [PW-1:0]  wptr_q, wptr_d;
    logic [PW-1:0]  rptr_q, rptr_d;
    logic [PW:0]    count_q, count_d;
    logic           ovf_q;
    logic [CNT_W-1:0] drop_cnt_q;
    logic           oob_err_q;
    logic [CNT_W-1:0] oob_cnt_q;

    assign addr_lsb_unused = ^m_data_addr[1:0];

    assign idx      = m_data_addr[31:2];
    assign in_range = ({2'b00, idx} < 32'(DEPTH));
    assign cur_word = in_range ? mem_q[idx[AW-1:0]] : 32'h0;
    assign any_be   = |m_data_byteen;
    assign wr_en    = reset & any_be & in_range;
    assign oob_wr   = reset & any_be & ~in_range;
    assign oob_rd   = reset & ~any_be & ~in_range;

    assign m_data_rdata = cur_word;

    always_comb begin
        merged = cur_word;
        for (int i = 0; i < 4; i++) begin
            if (m_data_byteen[i]) begin
                merged[8*i +: 8] = m_data_wdata[8*i +: 8];
            end
        end
    end

    // Memory is deliberately outside the reset domain so contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[idx[AW-1:0]] <= merged;
        end
    end

    assign full    = (count_q == (PW+1)'(TRACE_DEPTH));
    assign pop     = trace_valid & trace_ready;
    // A full FIFO can still accept a push when the head leaves on the same edge.
    assign do_push = wr_en & (~full | pop);
    assign drop    = wr_en & full & ~pop;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (do_push) begin
            wptr_d = wptr_q + 1'b1;
        end
        if (pop) begin
            rptr_d = rptr_q + 1'b1;
        end
        if (do_push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !do_push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            tpc_q[wptr_q]  <= m_inst_addr;
            tadr_q[wptr_q] <= {idx, 2'b00};
            tdat_q[wptr_q] <= merged;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
            drop_cnt_q <= '0;
            oob_err_q  <= 1'b0;
            oob_cnt_q  <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            if (drop) begin
                ovf_q <= 1'b1;
                if (drop_cnt_q != '1) begin
                    drop_cnt_q <= drop_cnt_q + 1'b1;
                end
            end
            if (oob_wr || oob_rd) begin
                oob_err_q <= 1'b1;
            end
            if (oob_wr && oob_cnt_q != '1) begin
                oob_cnt_q <= oob_cnt_q + 1'b1;
            end
        end
    end

    assign trace_valid = (count_q != '0);
    assign trace_count = count_q;
    assign trace_pc    = tpc_q[rptr_q];
    assign trace_addr  = tadr_q[rptr_q];
    assign trace_data  = tdat_q[rptr_q];
    assign trace_ovf   = ovf_q;
    assign drop_cnt    = drop_cnt_q;
    assign oob_err     = oob_err_q;
    assign oob_cnt     = oob_cnt_q;

endmodule
`default_nettype wire
